// File: rtl/led_flash_ctrl.sv
// led_flash_ctrl: push-button driven LED flasher.
// The button is synchronised and debounced. Each accepted press steps the mode
// OFF -> ON -> SLOW -> FAST -> CHASE -> OFF. A clock divider sets the blink and chase rate.
// The mode register doubles as the visible FSM state on the mode output.
// Optional macro LED_PWM_EN adds a duty input and a free-running PWM counter.
// The PWM counter dims every lit LED.
module led_flash_ctrl #(
    parameter int NUM_LEDS   = 2,
    parameter int CNT_W      = 26,
    parameter int SLOW_DIV   = 25000000,
    parameter int FAST_DIV   = 6250000,
    parameter int DEB_CYCLES = 1000000
`ifdef LED_PWM_EN
    ,
    parameter int PWM_W      = 4
`endif
) (
    input  logic                clk2,
    input  logic                rst,
    input  logic                btn,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0]    duty,
`endif
    output logic [NUM_LEDS-1:0] led,
    output logic [2:0]          mode,
    output logic                press
);

    typedef enum logic [2:0] {
        M_OFF   = 3'd0,
        M_ON    = 3'd1,
        M_SLOW  = 3'd2,
        M_FAST  = 3'd3,
        M_CHASE = 3'd4
    } mode_e;

    localparam logic [CNT_W-1:0]    DEB_LIM    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]    SLOW_LIM   = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0]    FAST_LIM   = CNT_W'(FAST_DIV - 1);
    localparam logic [NUM_LEDS-1:0] CHASE_INIT = NUM_LEDS'(1);

    logic                s1_q, s1_d, s2_q, s2_d;
    logic                db_q, db_d, db_prev_q, db_prev_d;
    logic                db_rise_q, db_rise_d, press_q, press_d;
    logic [CNT_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
    logic                phase_q, phase_d;
    logic [NUM_LEDS-1:0] chase_q, chase_d, chase_rot;
    logic [NUM_LEDS-1:0] led_q, led_d;
    mode_e               mode_q, mode_d;
    logic                blink, tick, entry;
    logic [CNT_W-1:0]    div_lim;

    // Synchroniser, debounce counter and the press pulse.
    // The press pulse is a retimed rising edge of db.
    always_comb begin
        s1_d      = btn;
        s2_d      = s1_q;
        db_d      = db_q;
        deb_cnt_d = '0;
        if (s2_q != db_q) begin
            if (deb_cnt_q == DEB_LIM) begin
                db_d = s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + CNT_W'(1);
            end
        end
        db_prev_d = db_q;
        db_rise_d = db_q & ~db_prev_q;
        press_d   = db_rise_q;
    end

    // Mode FSM next state; codes outside the legal set fall back to OFF.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            M_OFF:   if (press_q) mode_d = M_ON;
            M_ON:    if (press_q) mode_d = M_SLOW;
            M_SLOW:  if (press_q) mode_d = M_FAST;
            M_FAST:  if (press_q) mode_d = M_CHASE;
            M_CHASE: if (press_q) mode_d = M_OFF;
            default: mode_d = M_OFF;
        endcase
        entry = (mode_d != mode_q);
    end

    // One-hot chase pattern rotated left by one, top bit wrapping to bit 0.
    always_comb begin
        chase_rot = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            chase_rot[i] = chase_q[(i + NUM_LEDS - 1) % NUM_LEDS];
        end
    end

    // Divider and blink state. A mode change takes priority over a coincident tick.
    always_comb begin
        blink     = (mode_q == M_SLOW) || (mode_q == M_FAST) || (mode_q == M_CHASE);
        div_lim   = (mode_q == M_FAST) ? FAST_LIM : SLOW_LIM;
        tick      = blink && (div_cnt_q == div_lim);
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        chase_d   = chase_q;
        if (entry) begin
            div_cnt_d = '0;
            phase_d   = 1'b1;
            chase_d   = CHASE_INIT;
        end else if (!blink) begin
            div_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d = '0;
            phase_d   = ~phase_q;
            chase_d   = chase_rot;
        end else begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
        end
    end

    // LED pattern for the current mode; registered on the next edge.
    always_comb begin
        led_d = '0;
        case (mode_q)
            M_OFF:          led_d = '0;
            M_ON:           led_d = '1;
            M_SLOW, M_FAST: led_d = {NUM_LEDS{phase_q}};
            M_CHASE:        led_d = chase_q;
            default:        led_d = '0;
        endcase
    end

    // All state registers; asynchronous reset to idle.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            db_rise_q <= 1'b0;
            press_q   <= 1'b0;
            deb_cnt_q <= '0;
            div_cnt_q <= '0;
            phase_q   <= 1'b0;
            chase_q   <= CHASE_INIT;
            led_q     <= '0;
            mode_q    <= M_OFF;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            db_rise_q <= db_rise_d;
            press_q   <= press_d;
            deb_cnt_q <= deb_cnt_d;
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            chase_q   <= chase_d;
            led_q     <= led_d;
            mode_q    <= mode_d;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

    // Free-running PWM counter gating the lit LEDs.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    end

    // PWM counter register.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign led = led_q & {NUM_LEDS{pwm_cnt_q < duty}};
`else
    assign led = led_q;
`endif

    assign mode  = mode_q;
    assign press = press_q;

endmodule

// File: tb/tb_led_flash_ctrl.sv
// Testbench for led_flash_ctrl with NUM_LEDS=4, SLOW_DIV=8, FAST_DIV=2, DEB_CYCLES=4.
module tb_led_flash_ctrl;
  localparam int NL   = 4;
  localparam int SDIV = 8;
  localparam int FDIV = 2;
  localparam int DEB  = 4;

  logic          clk2 = 1'b0;
  logic          rst;
  logic          btn;
  logic [NL-1:0] led;
  logic [2:0]    mode;
  logic          press;

  int checks = 0;
  int passes = 0;

  led_flash_ctrl #(
    .NUM_LEDS(NL), .CNT_W(26), .SLOW_DIV(SDIV), .FAST_DIV(FDIV), .DEB_CYCLES(DEB)
  ) dut (
    .clk2(clk2), .rst(rst), .btn(btn), .led(led), .mode(mode), .press(press)
  );

  // clock / reset block
  always #5 clk2 = ~clk2;

  initial begin
    #500000;
    $display("FAIL global_timeout edge_count=%0d required=finish", checks);
    $fatal(1);
  end

  // Reference model. Works on edge numbers since reset release.
  // btn history gives the debounced level: it flips once the last DEB synchronised samples all differ from it.
  // A press follows 2 edges after a rising flip. The mode advances on the edge after the press.
  // The LEDs follow from the mode and the number of edges since mode entry.
  int            last_edge;
  logic          hist[$];
  logic [31:0]   exp_q[$];
  logic          db_m;
  int            mode_m;
  int            entry_m;
  logic          exp_press;
  logic [NL-1:0] exp_led;
  logic [2:0]    exp_mode;
  int            mn, mk, mdiv;
  logic          mflip, mv;

  always @(posedge clk2 or posedge rst) begin
    if (rst) begin
      last_edge = -1;
      hist.delete();
      exp_q.delete();
      db_m      = 1'b0;
      mode_m    = 0;
      entry_m   = 0;
      exp_press = 1'b0;
      exp_led   = '0;
      exp_mode  = 3'd0;
    end else begin
      last_edge = last_edge + 1;
      mn = last_edge;
      hist.push_back(btn);
      mdiv = (mode_m == 3) ? FDIV : SDIV;
      mk = (mn - entry_m - 1) / mdiv;
      case (mode_m)
        0:       exp_led = '0;
        1:       exp_led = '1;
        2, 3:    exp_led = (mk % 2 == 0) ? '1 : '0;
        default: exp_led = NL'(1) << (mk % NL);
      endcase
      if (exp_press) begin
        mode_m  = (mode_m + 1) % 5;
        entry_m = mn;
      end
      exp_mode  = 3'(mode_m);
      exp_press = 1'b0;
      if (exp_q.size() > 0 && exp_q[0] == 32'(mn)) begin
        exp_press = 1'b1;
        void'(exp_q.pop_front());
      end
      mflip = 1'b1;
      for (int i = mn - DEB - 1; i <= mn - 2; i++) begin
        mv = (i < 0) ? 1'b0 : hist[i];
        if (mv == db_m) mflip = 1'b0;
      end
      if (mflip) begin
        db_m = ~db_m;
        if (db_m) exp_q.push_back(32'(mn + 2));
      end
    end
  end

  // driver: apply btn at the falling edge, return at the next falling edge
  task automatic next_cycle(input logic b);
    btn = b;
    @(negedge clk2);
  endtask

  task automatic press_once();
    for (int i = 0; i < 12; i++) next_cycle(1'b1);
    for (int i = 0; i < 10; i++) next_cycle(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 1'b0;
    repeat (3) @(negedge clk2);
    checks++;
    if (led !== 4'b0000) $display("FAIL reset_led got=%b want=0000", led); else passes++;
    checks++;
    if (mode !== 3'd0) $display("FAIL reset_mode got=%0d want=0", mode); else passes++;
    checks++;
    if (press !== 1'b0) $display("FAIL reset_press got=%b want=0", press); else passes++;
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      next_cycle(1'b0);
      checks++;
      if (led !== 4'b0000 || mode !== 3'd0 || press !== 1'b0)
        $display("FAIL idle edge=%0d led=%b mode=%0d press=%b want 0000/0/0", last_edge, led, mode, press);
      else passes++;
    end
  endtask

  task automatic test_glitch();
    int npress = 0;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 6; i++) begin
        next_cycle((i < 2) ? 1'b1 : 1'b0);
        if (press === 1'b1) npress++;
        checks++;
        if (led !== exp_led || mode !== exp_mode || press !== exp_press)
          $display("FAIL glitch_model edge=%0d led=%b/%b mode=%0d/%0d press=%b/%b",
                   last_edge, led, exp_led, mode, exp_mode, press, exp_press);
        else passes++;
      end
    end
    checks++;
    if (npress != 0 || mode !== 3'd0) $display("FAIL glitch_rejected presses=%0d mode=%0d want 0/0", npress, mode);
    else passes++;
  endtask

  task automatic test_first_press();
    int e0 = last_edge + 1;
    int npress = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle(1'b1);
      checks++;
      if (press !== ((last_edge == e0 + 7) ? 1'b1 : 1'b0))
        $display("FAIL press_timing edge=%0d got=%b want=%b", last_edge - e0, press, (last_edge == e0 + 7));
      else passes++;
      if (last_edge == e0 + 8) begin
        checks++;
        if (mode !== 3'd1) $display("FAIL mode_on_edge8 got=%0d want=1", mode); else passes++;
      end
      if (last_edge == e0 + 9) begin
        checks++;
        if (led !== 4'b1111) $display("FAIL led_on_edge9 got=%b want=1111", led); else passes++;
      end
    end
    for (int i = 0; i < 15; i++) begin
      next_cycle(1'b0);
      if (press === 1'b1) npress++;
      checks++;
      if (led !== exp_led || mode !== exp_mode || press !== exp_press)
        $display("FAIL release_model edge=%0d led=%b/%b mode=%0d/%0d press=%b/%b",
                 last_edge, led, exp_led, mode, exp_mode, press, exp_press);
      else passes++;
    end
    checks++;
    if (npress != 0) $display("FAIL release_no_pulse got=%0d want=0", npress); else passes++;
  endtask

  task automatic test_fast_blink();
    int rises = 0;
    logic [NL-1:0] prev;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 22; i++) begin
        next_cycle((i < 12) ? 1'b1 : 1'b0);
        checks++;
        if (led !== exp_led || mode !== exp_mode || press !== exp_press)
          $display("FAIL fast_model edge=%0d led=%b/%b mode=%0d/%0d press=%b/%b",
                   last_edge, led, exp_led, mode, exp_mode, press, exp_press);
        else passes++;
      end
    end
    checks++;
    if (mode !== 3'd3) $display("FAIL fast_mode got=%0d want=3", mode); else passes++;
    prev = led;
    for (int i = 0; i < 8; i++) begin
      next_cycle(1'b0);
      checks++;
      if (led !== 4'b1111 && led !== 4'b0000) $display("FAIL fast_levels got=%b want=1111|0000", led);
      else passes++;
      if (prev == 4'b0000 && led == 4'b1111) rises++;
      prev = led;
    end
    checks++;
    if (rises != 2) $display("FAIL fast_rises got=%0d want=2", rises); else passes++;
  endtask

  task automatic test_chase();
    logic [NL-1:0] seq[5];
    int waited = 0;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    while (mode !== 3'd4 && waited < 30) begin
      next_cycle(1'b1);
      waited++;
    end
    checks++;
    if (mode !== 3'd4) $display("FAIL chase_entry got=%0d want=4", mode); else passes++;
    for (int i = 0; i < 40; i++) begin
      next_cycle(1'b1);
      checks++;
      if (led !== seq[i / 8]) $display("FAIL chase_seq step=%0d got=%b want=%b", i, led, seq[i / 8]);
      else passes++;
    end
    for (int i = 0; i < 10; i++) next_cycle(1'b0);
    for (int i = 0; i < 12; i++) next_cycle(1'b1);
    checks++;
    if (mode !== 3'd0 || led !== 4'b0000) $display("FAIL chase_to_off mode=%0d led=%b want 0/0000", mode, led);
    else passes++;
    for (int i = 0; i < 10; i++) next_cycle(1'b0);
  endtask

  task automatic test_reset_mid_chase();
    for (int p = 0; p < 4; p++) press_once();
    for (int i = 0; i < 3; i++) next_cycle(1'b1);
    checks++;
    if (mode !== 3'd4) $display("FAIL pre_reset_mode got=%0d want=4", mode); else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if (led !== 4'b0000 || mode !== 3'd0) $display("FAIL async_reset led=%b mode=%0d want 0000/0", led, mode);
    else passes++;
    @(negedge clk2);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next_cycle(1'b1);
      checks++;
      if (press !== ((last_edge == 7) ? 1'b1 : 1'b0))
        $display("FAIL held_press edge=%0d got=%b want=%b", last_edge, press, (last_edge == 7));
      else passes++;
      if (last_edge == 8) begin
        checks++;
        if (mode !== 3'd1) $display("FAIL held_mode got=%0d want=1", mode); else passes++;
      end
    end
  endtask

  task automatic test_random();
    logic b;
    int len;
    for (int s = 0; s < 60; s++) begin
      b = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        next_cycle(b);
        checks++;
        if (led !== exp_led || mode !== exp_mode || press !== exp_press)
          $display("FAIL random_model edge=%0d led=%b/%b mode=%0d/%0d press=%b/%b",
                   last_edge, led, exp_led, mode, exp_mode, press, exp_press);
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_first_press();
    test_fast_blink();
    test_chase();
    test_reset_mid_chase();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
